// File: rtl/mpsoc_dbg_ahb3_slave_mem.sv
// mpsoc_dbg_ahb3_slave_mem
//
// AHB3-Lite slave: word-organised SRAM model answering the debug unit's AHB master port.
// Each OKAY transfer takes WAIT_STATES wait cycles followed by one completing data cycle.
// Illegal transfers get the standard two-cycle ERROR response. Illegal means a bad size,
// a misaligned address, or an address beyond MEM_DEPTH words.
//
// Ports:
//   HCLK, HRESETn      bus clock, asynchronous active-low reset
//   HSEL, HADDR        slave select, byte address
//   HWRITE, HSIZE      direction, transfer size (0 byte, 1 half, 2 word)
//   HTRANS, HREADY     transfer type, bus ready (acceptance qualifier)
//   HBURST, HPROT,     accepted but ignored; bursts are handled as independent singles
//   HMASTLOCK
//   HWDATA / HRDATA    write data (data phase) / read data (zero outside read data cycles)
//   HREADYOUT, HRESP   slave ready, response (0 OKAY, 1 ERROR)
//   xfer_cnt           completed OKAY transfers, saturating at 16'hFFFF
module mpsoc_dbg_ahb3_slave_mem #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [15:0]           xfer_cnt
);

  localparam int unsigned IdxW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam bit          HasWait  = (WAIT_STATES > 0);
  localparam logic [3:0]  WaitLoad = HasWait ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StErr1,
    StErr2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      wait_q, wait_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [1:0]      lane_q, lane_d;
  logic [2:0]      size_q, size_d;
  logic            write_q, write_d;
  logic [15:0]     xfer_cnt_q;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Only meaningful in StIdle, StData and StErr2; the FSM only looks at it there.
  logic accept;
  assign accept = HSEL & HREADY & HTRANS[1];

  // Error classification of the address phase being offered.
  logic                  size_err;
  logic                  align_err;
  logic                  range_err;
  logic                  xfer_err;
  logic [ADDR_WIDTH-3:0] word_idx;

  assign word_idx  = HADDR[ADDR_WIDTH-1:2];
  assign size_err  = (HSIZE > 3'd2);
  assign align_err = ((HSIZE == 3'd1) && HADDR[0]) ||
                     ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
  assign range_err = ({2'b00, word_idx} >= ADDR_WIDTH'(MEM_DEPTH));
  assign xfer_err  = size_err | align_err | range_err;

  // Next-state logic; a completing cycle may take a new address phase back-to-back.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    size_d  = size_q;
    write_d = write_q;
    unique case (state_q)
      StWait: begin
        if (wait_q == 4'd0) begin
          state_d = StData;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      StErr1: begin
        state_d = StErr2;
      end
      default: begin
        state_d = StIdle;
        if (accept) begin
          idx_d   = HADDR[IdxW+1:2];
          lane_d  = HADDR[1:0];
          size_d  = HSIZE;
          write_d = HWRITE;
          if (xfer_err) begin
            state_d = StErr1;
          end else if (HasWait) begin
            state_d = StWait;
            wait_d  = WaitLoad;
          end else begin
            state_d = StData;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
      wait_q  <= 4'd0;
      idx_q   <= '0;
      lane_q  <= 2'b00;
      size_q  <= 3'd0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  logic in_data;
  assign in_data = (state_q == StData);

  // Completed OKAY transfer counter, sticks at all-ones.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      xfer_cnt_q <= 16'd0;
    end else if (in_data && (xfer_cnt_q != 16'hFFFF)) begin
      xfer_cnt_q <= xfer_cnt_q + 16'd1;
    end
  end

  assign xfer_cnt = xfer_cnt_q;

  // Little-endian byte enables from the captured low address bits and size.
  // Only legal sizes reach StData, so size_q is 0, 1 or 2 here.
  logic [3:0] byte_en;
  always_comb begin
    byte_en = 4'b0000;
    for (int l = 0; l < 4; l++) begin
      unique case (size_q)
        3'd0:    byte_en[l] = (2'(l) == lane_q);
        3'd1:    byte_en[l] = (l / 2 == int'(lane_q[1]));
        default: byte_en[l] = 1'b1;
      endcase
    end
  end

  // Memory is deliberately not reset. Gating with HRESETn drops a write whose
  // closing edge coincides with reset being held.
  logic do_write;
  assign do_write = in_data & write_q & HRESETn;

  always_ff @(posedge HCLK) begin
    if (do_write) begin
      for (int l = 0; l < 4; l++) begin
        if (byte_en[l]) begin
          mem[idx_q][8*l +: 8] <= HWDATA[8*l +: 8];
        end
      end
    end
  end

  // Asynchronous array read, so a write committed at the previous edge is visible.
  always_comb begin
    HRDATA = '0;
    if (in_data && !write_q) begin
      HRDATA = mem[idx_q];
    end
  end

  assign HREADYOUT = !((state_q == StWait) || (state_q == StErr1));
  assign HRESP     = (state_q == StErr1) || (state_q == StErr2);

  logic unused_inputs;
  assign unused_inputs = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK};

endmodule

// File: tb/tb_mpsoc_dbg_ahb3_slave_mem.sv
// Bench for mpsoc_dbg_ahb3_slave_mem. Three instances share one bus with
// WAIT_STATES = 0, 1 and 3, and only the instance under test is selected.
// Stimulus pushes transfer descriptors into a queue. The monitor pops a
// descriptor when that transfer's data phase ends and checks the response
// against a byte-level memory model.
module tb_mpsoc_dbg_ahb3_slave_mem;

  localparam int NDUT = 3;

  function automatic int ws_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
  endfunction

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NDUT-1:0] hsel = '0;
  logic [31:0]     haddr = '0;
  logic [31:0]     hwdata = '0;
  logic            hwrite = 1'b0;
  logic [2:0]      hsize = 3'd0;
  logic [2:0]      hburst = 3'd0;
  logic [3:0]      hprot = 4'b0011;
  logic [1:0]      htrans = 2'b00;
  logic            hmastlock = 1'b0;

  wire [NDUT-1:0] hreadyout;
  wire [NDUT-1:0] hresp;
  wire [31:0]     hrdata   [NDUT];
  wire [15:0]     xfer_cnt [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mpsoc_dbg_ahb3_slave_mem #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .MEM_DEPTH  (256),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .HCLK     (clk),
      .HRESETn  (rst_n),
      .HSEL     (hsel[g]),
      .HADDR    (haddr),
      .HWDATA   (hwdata),
      .HRDATA   (hrdata[g]),
      .HWRITE   (hwrite),
      .HSIZE    (hsize),
      .HBURST   (hburst),
      .HPROT    (hprot),
      .HTRANS   (htrans),
      .HMASTLOCK(hmastlock),
      .HREADY   (hreadyout[g]),
      .HREADYOUT(hreadyout[g]),
      .HRESP    (hresp[g]),
      .xfer_cnt (xfer_cnt[g])
    );
  end

  typedef struct {
    logic [31:0] addr;
    bit          write;
    logic [2:0]  size;
    logic [31:0] wdata;
    bit          err;
    int          waits;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cur = 0;
  logic [7:0]  ref_mem [NDUT][1024];
  bit          known   [NDUT][1024];
  int unsigned xcnt    [NDUT];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s dut=%0d actual=%h required=%h t=%0t", name, cur, act, req, $time);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
    return (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00) ||
           (a[31:2] >= 30'd256);
  endfunction

  // Monitor / scoreboard
  bit          in_dp = 1'b0;
  int          low_cnt = 0;
  exp_t        mon_e;
  logic [31:0] mon_mask;
  logic [31:0] mon_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      in_dp = 1'b0;
      low_cnt = 0;
      for (int i = 0; i < NDUT; i++) xcnt[i] = 0;
    end else begin
      if (in_dp) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
          in_dp = 1'b0;
        end else if (hreadyout[cur]) begin
          mon_e = exp_q.pop_front();
          chk("resp_done", 32'(hresp[cur]), 32'(mon_e.err));
          chk("wait_cycles", 32'(low_cnt), 32'(mon_e.waits));
          if (!mon_e.err && !mon_e.write) begin
            mon_mask = '0;
            mon_exp  = '0;
            for (int l = 0; l < 4; l++) begin
              int ba;
              ba = int'({mon_e.addr[9:2], 2'b00}) + l;
              if (known[cur][ba]) begin
                mon_mask[8*l +: 8] = 8'hFF;
                mon_exp[8*l +: 8]  = ref_mem[cur][ba];
              end
            end
            chk("rdata", hrdata[cur] & mon_mask, mon_exp);
          end else begin
            chk("rdata_zero", hrdata[cur], 32'd0);
          end
          if (!mon_e.err) begin
            if (mon_e.write) begin
              for (int l = 0; l < 4; l++) begin
                bit en;
                int ba;
                en = (mon_e.size == 3'd0) ? (l == int'(mon_e.addr[1:0])) :
                     (mon_e.size == 3'd1) ? ((l / 2) == int'(mon_e.addr[1])) : 1'b1;
                ba = int'({mon_e.addr[9:2], 2'b00}) + l;
                if (en) begin
                  ref_mem[cur][ba] = mon_e.wdata[8*l +: 8];
                  known[cur][ba]   = 1'b1;
                end
              end
            end
            if (xcnt[cur] < 32'hFFFF) xcnt[cur]++;
          end
          in_dp = 1'b0;
        end else begin
          low_cnt++;
          chk("resp_wait", 32'(hresp[cur]), 32'(exp_q[0].err));
          chk("rdata_wait", hrdata[cur], 32'd0);
          if (low_cnt > 20) begin
            chk("wait_bound", 32'(low_cnt), 32'd20);
            in_dp = 1'b0;
          end
        end
      end else begin
        chk("idle_ready", 32'(hreadyout[cur]), 32'd1);
        chk("idle_resp", 32'(hresp[cur]), 32'd0);
        chk("idle_rdata", hrdata[cur], 32'd0);
      end
      if (hreadyout[cur] && hsel[cur] && htrans[1]) begin
        in_dp = 1'b1;
        low_cnt = 0;
      end
    end
  end

  // Stimulus helpers; inputs always change 1 time unit after a rising edge.
  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!hreadyout[cur] && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input bit w, input logic [2:0] sz,
                       input logic [31:0] wd, input logic [1:0] tr);
    exp_t e;
    haddr  = a;
    hwrite = w;
    hsize  = sz;
    htrans = tr;
    hsel   = '0;
    hsel[cur] = 1'b1;
    e.addr  = a;
    e.write = w;
    e.size  = sz;
    e.wdata = wd;
    e.err   = is_err(a, sz);
    e.waits = e.err ? 1 : ws_of(cur);
    exp_q.push_back(e);
    wait_ready();
    hwdata = wd;
  endtask

  task automatic busy(input logic [31:0] a);
    haddr  = a;
    hwrite = 1'b1;
    hsize  = 3'd2;
    htrans = 2'b01;
    hsel   = '0;
    hsel[cur] = 1'b1;
    wait_ready();
    hwdata = 32'hBAD0BAD0;
  endtask

  task automatic idle(input int n);
    htrans = 2'b00;
    hsel   = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_cnt(input string name);
    idle(ws_of(cur) + 3);
    @(negedge clk);
    chk(name, 32'(xfer_cnt[cur]), xcnt[cur]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;

    // Reset values on every instance, then idle cycles after release.
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk("rst_ready", 32'(hreadyout[i]), 32'd1);
      chk("rst_resp", 32'(hresp[i]), 32'd0);
      chk("rst_rdata", hrdata[i], 32'd0);
      chk("rst_cnt", 32'(xfer_cnt[i]), 32'd0);
    end
    rst_n = 1'b1;
    idle(5);
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      chk("post_idle_ready", 32'(hreadyout[i]), 32'd1);
      chk("post_idle_cnt", 32'(xfer_cnt[i]), 32'd0);
    end
    @(posedge clk);
    #1;

    // One wait state: word write then word read of 0x10.
    cur = 1;
    issue(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 2'b10);
    issue(32'h10, 1'b0, 3'd2, 32'h0, 2'b10);
    chk_cnt("cnt_ws1_model");
    chk("cnt_ws1_two", 32'(xfer_cnt[1]), 32'd2);

    // Zero wait states: lane writes back-to-back, read merged word.
    cur = 0;
    issue(32'h10, 1'b1, 3'd2, 32'h0000_0000, 2'b10);
    issue(32'h13, 1'b1, 3'd0, 32'hAA00_0000, 2'b10);
    issue(32'h10, 1'b1, 3'd1, 32'h0000_5566, 2'b10);
    issue(32'h10, 1'b0, 3'd2, 32'h0, 2'b10);
    chk_cnt("cnt_ws0");

    // ERROR responses; a NONSEQ offered during ERR2 completes OKAY.
    cur = 1;
    issue(32'h0, 1'b1, 3'd2, 32'hCAFEF00D, 2'b10);
    idle(3);
    issue(32'h2, 1'b1, 3'd2, 32'hFFFF_FFFF, 2'b10);
    issue(32'h400, 1'b1, 3'd2, 32'h1234_4321, 2'b10);
    issue(32'h0, 1'b0, 3'd2, 32'h0, 2'b10);
    chk_cnt("cnt_err");
    issue(32'h0, 1'b0, 3'd2, 32'h0, 2'b10);
    chk_cnt("cnt_err_read");

    // INCR4 with a BUSY beat; BUSY points at a preloaded word that must survive.
    issue(32'h50, 1'b1, 3'd2, 32'h5050_5050, 2'b10);
    idle(2);
    hburst = 3'b011;
    issue(32'h40, 1'b1, 3'd2, 32'hA000_0040, 2'b10);
    issue(32'h44, 1'b1, 3'd2, 32'hA000_0044, 2'b11);
    busy(32'h50);
    issue(32'h48, 1'b1, 3'd2, 32'hA000_0048, 2'b11);
    issue(32'h4C, 1'b1, 3'd2, 32'hA000_004C, 2'b11);
    hburst = 3'b000;
    idle(2);
    for (int i = 0; i < 5; i++) issue(32'h40 + 32'(4 * i), 1'b0, 3'd2, 32'h0, 2'b10);
    chk_cnt("cnt_burst");

    // Randomized traffic on each instance.
    for (int d = 0; d < NDUT; d++) begin
      cur = d;
      for (int n = 0; n < 150; n++) begin
        if ($urandom_range(0, 9) == 0) a = 32'h400 + 32'($urandom_range(0, 255));
        else a = 32'($urandom_range(0, 63));
        sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        if ($urandom_range(0, 3) != 0) begin
          if (sz == 3'd1) a[0] = 1'b0;
          if (sz == 3'd2) a[1:0] = 2'b00;
        end
        issue(a, 1'($urandom_range(0, 1)), sz, $urandom(), 2'b10);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      end
      chk_cnt("cnt_random");
    end

    // Reset during WAIT of a write discards it and clears the counter.
    cur = 2;
    issue(32'h20, 1'b1, 3'd2, 32'h1111_1111, 2'b10);
    idle(6);
    issue(32'h20, 1'b1, 3'd2, 32'h1234_5678, 2'b10);
    htrans = 2'b00;
    hsel   = '0;
    rst_n  = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_ready", 32'(hreadyout[2]), 32'd1);
    chk("abort_cnt", 32'(xfer_cnt[2]), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    issue(32'h20, 1'b0, 3'd2, 32'h0, 2'b10);
    chk_cnt("cnt_after_abort");

    // Counter saturation on the zero-wait instance.
    cur = 0;
    issue(32'h0, 1'b1, 3'd2, 32'h0BAD_F00D, 2'b10);
    for (int i = 0; i < 32'hFFFD; i++) issue(32'h0, 1'b0, 3'd2, 32'h0, 2'b10);
    chk_cnt("cnt_preload");
    chk("cnt_fffe", 32'(xfer_cnt[0]), 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) issue(32'h0, 1'b0, 3'd2, 32'h0, 2'b10);
    chk_cnt("cnt_sat");
    chk("cnt_ffff", 32'(xfer_cnt[0]), 32'h0000_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
